// File: rtl/sram_pixel_writer.sv
// sram_pixel_writer: accepts pixel/fill commands and drives timed asynchronous SRAM write cycles
module sram_pixel_writer #(
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int WE_CYCLES = 2
) (
    input  logic        CLOCK_50_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_op_i,
    input  logic [8:0]  cmd_x_i,
    input  logic [7:0]  cmd_y_i,
    input  logic [15:0] cmd_color_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [19:0] sram_addr_o,
    output logic [15:0] sram_dq_out_o,
    output logic        sram_dq_oe_o,
    output logic        sram_we_n_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_lb_n_o,
    output logic        sram_ub_n_o
);
    localparam logic [19:0] LAST = 20'(H_RES * V_RES - 1);
    localparam int CW = WE_CYCLES > 1 ? $clog2(WE_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;
    state_t state_q, state_d;
    logic op_q, op_d, done_q, done_d, err_q, err_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic accept, in_range;
    assign cmd_ready_o = state_q == IDLE && !reset_i;
    assign accept = cmd_valid_i && cmd_ready_o;
    assign in_range = 32'(cmd_x_i) < H_RES && 32'(cmd_y_i) < V_RES;
    always_ff @(posedge CLOCK_50_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    // Address and data stay registered across SETUP/WRITE/HOLD so we_n only moves with stable buses.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = accept && !cmd_op_i && !in_range;
        case (state_q)
            IDLE: begin
                if (accept && (cmd_op_i || in_range)) begin
                    state_d = SETUP;
                    op_d    = cmd_op_i;
                    data_d  = cmd_color_i;
                    addr_d  = cmd_op_i ? '0 : 20'(32'(cmd_y_i) * H_RES + 32'(cmd_x_i));
                end
            end
            SETUP: begin
                state_d = WRITE;
                cnt_d   = '0;
            end
            WRITE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WE_CYCLES - 1) ? HOLD : WRITE;
            end
            HOLD: begin
                if (!op_q || addr_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SETUP;
                    addr_d  = addr_q + 20'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy_o        = state_q != IDLE;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign sram_addr_o   = addr_q;
    assign sram_dq_out_o = data_q;
    assign sram_dq_oe_o  = busy_o;
    assign sram_ce_n_o   = !busy_o;
    assign sram_lb_n_o   = !busy_o;
    assign sram_ub_n_o   = !busy_o;
    assign sram_we_n_o   = state_q != WRITE;
    assign sram_oe_n_o   = 1'b1;
endmodule

// File: doc/sram_pixel_writer.md
# sram_pixel_writer

Write-side engine for the 16-bit pixel frame buffer in external SRAM. The VGA path scans this buffer out. The block accepts single-pixel writes and whole-frame fill commands through a valid/ready port, converts (x, y) to a linear SRAM word address, and drives the asynchronous SRAM write cycle with guaranteed setup and hold. It sits between the processor-side command source and the SRAM pins, on the CLOCK_50 domain.

## Interface
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame; H_RES*V_RES ≤ 2^20
- WE_CYCLES, 2, clocks sram_we_n held low per write (≥1)

Ports:
- CLOCK_50  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; high only in IDLE
- cmd_op  in  1  0 = write pixel, 1 = fill frame
- cmd_x  in  9  pixel column (ignored for fill)
- cmd_y  in  8  pixel row (ignored for fill)
- cmd_color  in  16  RGB565 pixel value
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on command completion
- err  out  1  one-cycle pulse for an out-of-range pixel command
- sram_addr  out  20  word address
- sram_dq_out  out  16  write data
- sram_dq_oe  out  1  tristate enable for SRAM_DQ
- sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes

## Operation
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. The block captures op, x, y, and color on that edge. While busy, cmd_valid is ignored; there is no queueing.
- Address: addr = y*H_RES + x, computed at acceptance and zero-extended to 20 bits.
- Range check (pixel op): x ≥ H_RES or y ≥ V_RES → the command is accepted, err pulses in the next cycle, and the block stays in IDLE. No SRAM activity and no done pulse.
- States:
  - IDLE → SETUP on a valid in-range accept.
  - SETUP (1 cycle): addr and data driven, dq_oe=1, ce_n=0, lb_n=ub_n=0, we_n=1.
  - WRITE (WE_CYCLES cycles): we_n=0, addr and data stable.
  - HOLD (1 cycle): we_n=1, addr, data and dq_oe still held.
  - HOLD → IDLE for a pixel op, or for a fill once the last address is written. Otherwise HOLD → SETUP with addr+1.
- Fill writes addresses 0 .. H_RES*V_RES−1 in ascending order, all with the captured color. The address counter stops at the last address and never wraps.
- oe_n is held at 1 at all times; the block never reads.
- In IDLE: ce_n=lb_n=ub_n=1 and dq_oe=0. sram_addr and sram_dq_out hold their last values.
- done is asserted in the first IDLE cycle after the final HOLD.
- Reset mid-operation:
  - On the next edge, the state goes to IDLE and all outputs take reset values.
  - The fill counter is cleared.
  - No done is produced, and the aborted command is lost.

## Timing
- Reset values: cmd_ready=0 during reset cycles, 1 in the first cycle after reset deasserts. busy=0, done=0, err=0, sram_addr=0, sram_dq_out=0, dq_oe=0, we_n=ce_n=oe_n=lb_n=ub_n=1.
- Pixel write, acceptance on edge E0:
  - SETUP after E0.
  - WRITE after E1 .. E(WE_CYCLES).
  - HOLD after E(WE_CYCLES+1).
  - IDLE with done=1 and cmd_ready=1 after E(WE_CYCLES+2).
  - Earliest next accept is on edge E(WE_CYCLES+3).
- Fill: WE_CYCLES+2 cycles per pixel, back-to-back. done follows edge E(N*(WE_CYCLES+2)), where N=H_RES*V_RES.
- we_n falls only with addr and data already stable for ≥1 cycle. It rises ≥1 cycle before addr, data or dq_oe change.
- done and err never assert in the same cycle. Neither asserts while cmd_ready=0.

## Test plan
- Reset: hold reset 3 cycles with cmd_valid=1 → all outputs at reset values, no accept, cmd_ready=1 one cycle after release.
- Pixel write (x=5, y=2, color=0xF800), WE_CYCLES=2, accept on E0:
  - sram_addr=645 and dq_out=0xF800 from E0.
  - we_n low exactly after E1 and E2.
  - done=1 after E4.
  - cmd_ready low for 4 cycles.
- Out of range (x=320, y=0) and (x=0, y=240) → err pulse the cycle after accept. we_n stays 1, dq_oe stays 0, no done, cmd_ready stays 1.
- Fill with color=0x001F:
  - exactly 76800 we_n low pulses of 2 cycles each.
  - addresses 0..76799 strictly ascending, data always 0x001F.
  - done once, after edge 307200.
- Reset during fill after pixel 100's SETUP → next cycle we_n=1, dq_oe=0, busy=0, no done. A new pixel command (x=0, y=0) then completes normally at addr 0.
- Back-to-back pressure: cmd_valid held high with changing payloads → only payloads present on cycles where cmd_ready=1 are written. No SRAM write overlaps another.
